// File: rtl/multimemory_pkg.sv
// Shared types and helpers for the banked multi-requester memory.
// The low address bits select the bank; the remaining bits select the word inside that bank.
package multimemory_pkg;

    // Width of the requester-id and bank-index tags carried down the read pipeline.
    localparam int TAG_W = 8;

    // Number of address bits that select a bank (zero for a single bank).
    function automatic int bank_bits(input int banks);
        return (banks > 1) ? $clog2(banks) : 0;
    endfunction

    // One slot of the read-response pipeline.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] id;
        logic [TAG_W-1:0] bank;
    } rd_pipe_t;

    // Bank index of a word address: its low nbits bits.
    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int nbits);
        return addr & ((32'd1 << nbits) - 32'd1);
    endfunction

endpackage

// File: rtl/banked_multimemory_rr_arbiter.sv
// Per-bank arbiter. Grants at most one requester per cycle, one-hot.
// MULTIMEM_ROUND_ROBIN_EN defined: round-robin, priority starts after the last
// granted requester and the pointer moves only when advance is high and a grant is made.
// Undefined: fixed priority, lowest index wins, no state.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

`ifdef MULTIMEM_ROUND_ROBIN_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  w_next_ptr;
    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_req_rot;
    logic [N-1:0]   w_gnt_rot;
    logic [2*N-1:0] w_gnt_dbl;

    // Rotate requests so the pointer position is bit 0, pick the lowest, rotate the grant back.
    always_comb begin
        w_req_dbl  = {req, req} >> r_ptr;
        w_req_rot  = w_req_dbl[N-1:0];
        w_gnt_rot  = w_req_rot & (~w_req_rot + 1'b1);
        w_gnt_dbl  = {w_gnt_rot, w_gnt_rot} << r_ptr;
        grant      = w_gnt_dbl[2*N-1:N];
        w_next_ptr = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                w_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Pointer moves past the winner only on an actual grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && (|grant)) begin
            r_ptr <= w_next_ptr;
        end
    end
`else
    logic w_unused;

    // Fixed priority: isolate the lowest set request bit.
    always_comb begin
        grant    = req & (~req + 1'b1);
        w_unused = ^{clk, rst, advance};
    end
`endif

endmodule

// File: rtl/banked_multimemory.sv
// Banked multi-requester RAM. Every requester owns a read and a write port;
// each bank has its own read and write arbiter, so different banks work in parallel.
// Read data returns DATA_LAT cycles after acceptance, only to the issuing requester.
// Valid/ready: a transfer happens when valid && ready in the same cycle; ready is
// combinational from valid and arbiter state and is never high without valid; the
// requester holds valid/addr/data stable until accepted.
// Optional feature macro: MULTIMEM_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module banked_multimemory
    import multimemory_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int BANKS      = 4,
    parameter int DATA_LAT   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] r_addr,
    input  logic [REQUESTERS-1:0]            r_avalid,
    output logic [REQUESTERS-1:0]            r_aready,
    output logic [REQUESTERS-1:0]            r_dvalid,
    output logic [REQUESTERS*DATA_WIDTH-1:0] r_data,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] w_addr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] w_data,
    input  logic [REQUESTERS-1:0]            w_valid,
    output logic [REQUESTERS-1:0]            w_ready
);

    localparam int BANK_BITS  = bank_bits(BANKS);
    localparam int BANK_IDX_W = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int WORD_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int WORD_W     = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int DEPTH      = 1 << WORD_BITS;

    logic [BANK_IDX_W-1:0] w_rbank [REQUESTERS];
    logic [BANK_IDX_W-1:0] w_wbank [REQUESTERS];
    logic [WORD_W-1:0]     w_rword [REQUESTERS];
    logic [WORD_W-1:0]     w_wword [REQUESTERS];
    logic [REQUESTERS-1:0] w_rreq  [BANKS];
    logic [REQUESTERS-1:0] w_wreq  [BANKS];
    logic [REQUESTERS-1:0] w_rgnt  [BANKS];
    logic [REQUESTERS-1:0] w_wgnt  [BANKS];
    logic [WORD_W-1:0]     w_rd_word [BANKS];
    logic [TAG_W-1:0]      w_rd_id   [BANKS];
    logic                  w_block;
    logic                  w_adv;
    logic                  r_rst_q;

    logic [DATA_WIDTH-1:0] r_mem   [BANKS][DEPTH];
    rd_pipe_t              r_pipe  [DATA_LAT][BANKS];
    logic [DATA_WIDTH-1:0] r_dpipe [DATA_LAT][BANKS];

    // Nothing is accepted during reset nor in the cycle right after it.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    always_comb begin
        w_block = rst | r_rst_q;
        w_adv   = ~w_block;
    end

    // Split every requester address into bank index and in-bank word address.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            w_rbank[i] = BANK_IDX_W'(bank_of(32'(r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), BANK_BITS));
            w_wbank[i] = BANK_IDX_W'(bank_of(32'(w_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), BANK_BITS));
            w_rword[i] = WORD_W'(r_addr[i*ADDR_WIDTH +: ADDR_WIDTH] >> BANK_BITS);
            w_wword[i] = WORD_W'(w_addr[i*ADDR_WIDTH +: ADDR_WIDTH] >> BANK_BITS);
        end
    end

    // Arbitration candidates per bank: valid requesters addressing that bank.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            w_rreq[b] = '0;
            w_wreq[b] = '0;
            for (int i = 0; i < REQUESTERS; i++) begin
                w_rreq[b][i] = r_avalid[i] && (w_rbank[i] == BANK_IDX_W'(b));
                w_wreq[b][i] = w_valid[i] && (w_wbank[i] == BANK_IDX_W'(b));
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        rr_arbiter #(.N(REQUESTERS)) u_rd_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (w_rreq[b]),
            .advance (w_adv),
            .grant   (w_rgnt[b])
        );
        rr_arbiter #(.N(REQUESTERS)) u_wr_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (w_wreq[b]),
            .advance (w_adv),
            .grant   (w_wgnt[b])
        );
    end

    // Ready is the union of the per-bank grants, masked around reset.
    always_comb begin
        r_aready = '0;
        w_ready  = '0;
        if (!w_block) begin
            for (int b = 0; b < BANKS; b++) begin
                r_aready = r_aready | w_rgnt[b];
                w_ready  = w_ready | w_wgnt[b];
            end
        end
    end

    // Word address and requester id of the read winner in each bank.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            w_rd_word[b] = '0;
            w_rd_id[b]   = '0;
            for (int i = 0; i < REQUESTERS; i++) begin
                if (w_rgnt[b][i]) begin
                    w_rd_word[b] = w_rword[i];
                    w_rd_id[b]   = TAG_W'(i);
                end
            end
        end
    end

    // Bank write port: only the granted writer updates the bank word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (!w_block && w_wgnt[b][i]) begin
                    r_mem[b][w_wword[i]] <= w_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read pipeline: the word is sampled at acceptance (old value on a same-cycle write)
    // and travels with its id/bank tag; reset flushes every in-flight response.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            r_pipe[0][b].valid <= !w_block && (|w_rgnt[b]);
            r_pipe[0][b].id    <= w_rd_id[b];
            r_pipe[0][b].bank  <= TAG_W'(b);
            r_dpipe[0][b]      <= r_mem[b][w_rd_word[b]];
            for (int s = 1; s < DATA_LAT; s++) begin
                r_pipe[s][b]  <= r_pipe[s-1][b];
                r_dpipe[s][b] <= r_dpipe[s-1][b];
            end
        end
        if (rst) begin
            for (int s = 0; s < DATA_LAT; s++) begin
                for (int b = 0; b < BANKS; b++) begin
                    r_pipe[s][b].valid <= 1'b0;
                end
            end
        end
    end

    // Route each finished slot to its requester; data is zero whenever dvalid is low.
    always_comb begin
        r_dvalid = '0;
        r_data   = '0;
        if (!rst) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int i = 0; i < REQUESTERS; i++) begin
                    if (r_pipe[DATA_LAT-1][b].valid &&
                        r_pipe[DATA_LAT-1][b].id == TAG_W'(i) &&
                        r_pipe[DATA_LAT-1][b].bank == TAG_W'(b)) begin
                        r_dvalid[i] = 1'b1;
                        r_data[i*DATA_WIDTH +: DATA_WIDTH] = r_dpipe[DATA_LAT-1][b];
                    end
                end
            end
        end
    end

endmodule

// File: doc/banked_multimemory.md
# banked_multimemory

Banked, multi-requester RAM and the next generation of the shared single-bank memory. Up to REQUESTERS clients each own one read port and one write port, and BANKS independent pseudo-dual-port banks are arbitrated per bank. Requests to different banks proceed in parallel. Read data is routed back only to the requester that issued the read, with a fixed, parametrised latency.

## Interface
- REQUESTERS, 4: number of client read/write port pairs (≥1)
- DATA_WIDTH, 32: word width
- ADDR_WIDTH, 6: word address width
- BANKS, 4: bank count, a power of two, ≤ 2^ADDR_WIDTH; bank = addr[log2(BANKS)-1:0]
- DATA_LAT, 2: cycles from read acceptance to r_dvalid (≥1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- r_addr  in  REQUESTERS×ADDR_WIDTH  read address per requester
- r_avalid  in  REQUESTERS  read request valid
- r_aready  out  REQUESTERS  read request accepted this cycle
- r_dvalid  out  REQUESTERS  read data valid
- r_data  out  REQUESTERS×DATA_WIDTH  read data per requester
- w_addr  in  REQUESTERS×ADDR_WIDTH  write address
- w_data  in  REQUESTERS×DATA_WIDTH  write data
- w_valid  in  REQUESTERS  write request valid
- w_ready  out  REQUESTERS  write accepted this cycle

## Operation
- Handshake: a transfer occurs in a cycle where valid && ready. Ready is combinational from valid and arbiter state. Ready is never asserted without the matching valid. A requester holds valid/addr/data stable until accepted.
- Each bank has one read arbiter and one write arbiter.
  - Candidates are the requesters whose valid is high and whose address selects that bank.
  - Each arbiter grants at most one candidate per cycle.
  - Read and write arbitration are independent: one read and one write per bank per cycle.
- Arbitration policy is set by the macro (see Configuration).
- Accepted write: the bank word at addr[ADDR_WIDTH-1:log2(BANKS)] is updated at the end of the acceptance cycle.
- Accepted read: the bank word is read. The bank index and requester id travel down a DATA_LAT-deep pipeline, and the word is delivered on r_data[id] with r_dvalid[id]=1 for exactly one cycle.
- One requester may have up to DATA_LAT reads in flight. Responses return in acceptance order, one per cycle at most.
- r_data[i] is driven to 0 whenever r_dvalid[i]=0.
- Same-cycle read and write to the same address: the read returns the old word (read-before-write).
- Two writers to the same bank and cycle: only the granted one is written. The loser keeps w_valid and is served later.
- Memory contents are not reset and are undefined until written.

## Timing
- During rst and in the first cycle after:
  - r_aready, w_ready, r_dvalid are 0 and r_data is 0.
  - Arbiter state returns to its reset value: RR pointer 0, meaning requester 0 has highest priority.
- Read accepted in cycle T → r_dvalid in cycle T+DATA_LAT.
- A write accepted in T is visible to a read accepted in T+1.
- Reset mid-operation: the pipeline is flushed, and no r_dvalid is produced for reads accepted before rst. Writes accepted before the rst cycle are retained.
- Throughput: BANKS reads + BANKS writes per cycle with no conflicts.

## Configuration
- MULTIMEM_ROUND_ROBIN_EN defined: per-bank round-robin. After a grant to requester g, priority starts at g+1 (mod REQUESTERS). The pointer advances only on a grant. No starvation: worst case REQUESTERS-1 cycles of waiting.
- Undefined: fixed priority, lowest index wins, and there is no pointer state.

## Structure
- Package multimemory_pkg:
  - localparam BANK_BITS = $clog2(BANKS) (as a function of parameters)
  - typedef for the read pipeline entry {valid, requester id, bank index}
  - function bank_of(addr)
- Sub-module rr_arbiter #(N), instantiated 2×BANKS times:
  - inputs: req[N], advance
  - output: one-hot grant[N]
  - the pointer register exists only under MULTIMEM_ROUND_ROBIN_EN

## Test plan
- Default params: requester 0 writes 0xA5A5_0001 to addr 5, then reads addr 5 one cycle later → r_dvalid[0] exactly 2 cycles after r_aready[0], r_data[0]=0xA5A5_0001, other r_dvalid stay 0.
- Requesters 0..3 read addrs 0,1,2,3 (all different banks) in the same cycle → all r_aready=1 in that cycle, all four r_dvalid together 2 cycles later with each requester's own data.
- Requesters 0..3 hold reads to addr 4 (bank 0) with RR enabled → grants occur in order 0,1,2,3 on consecutive cycles. With the macro undefined → grants 0,1,2,3 only because each drops valid after acceptance. Requester 0 held continuously starves the others.
- Same cycle: write 0x1234 and read addr 7, which holds 0x0BAD → read returns 0x0BAD. A read in the next cycle returns 0x1234.
- Read accepted, then rst asserted on the next cycle → no r_dvalid appears. After rst, all ready outputs are 0 for one cycle and the RR pointer is back at 0.
- Sweep DATA_LAT=1,4 and BANKS=1 → latency equals DATA_LAT. With BANKS=1, at most one read and one write are accepted per cycle.
